// File: rtl/tpu_isa_pkg.sv
// Shared ISA definitions for the TPU front end: opcode encodings, opcode field
// position and the fetch sequencer state encoding. The decoder imports this too.
package tpu_isa_pkg;

   localparam int INSTR_W = 16;
   localparam int OPC_W   = 3;
   localparam int OPC_MSB = INSTR_W - 1;
   localparam int OPC_LSB = INSTR_W - OPC_W;

   localparam logic [OPC_W-1:0] OP_NOP         = 3'b000;
   localparam logic [OPC_W-1:0] OP_LOAD_ADDR   = 3'b001;
   localparam logic [OPC_W-1:0] OP_LOAD_WEIGHT = 3'b010;
   localparam logic [OPC_W-1:0] OP_LOAD_INPUTS = 3'b011;
   localparam logic [OPC_W-1:0] OP_COMPUTE     = 3'b100;
   localparam logic [OPC_W-1:0] OP_HALT        = 3'b111;

   typedef enum logic [2:0] {
      FS_IDLE,
      FS_FETCH,
      FS_RECV,
      FS_ISSUE,
      FS_WAIT_CMP,
      FS_DONE
   } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory read port: the fetch unit drives enable/address and
// receives the read word one cycle after the enable.
interface instruction_fetch_if #(
   parameter int IMEM_AW = 8,
   parameter int INSTR_W = 16
) ();

   logic               imem_en;
   logic [IMEM_AW-1:0] imem_addr;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (
      output imem_en,
      output imem_addr,
      input  imem_rdata
   );

   modport slave (
      input  imem_en,
      input  imem_addr,
      output imem_rdata
   );

endinterface

// File: rtl/instruction_fetch.sv
// Fetch sequencer feeding the instruction decoder: reads one word per fetch,
// issues it for a single cycle, and honours stall, compute-wait and HALT.
module instruction_fetch #(
   parameter int IMEM_AW = 8,
   parameter int INSTR_W = tpu_isa_pkg::INSTR_W,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [IMEM_AW-1:0] start_pc,
   input  logic               stall,
   input  logic               compute_done,
   instruction_fetch_if.master imem,
   output logic [INSTR_W-1:0] instruction,
   output logic [IMEM_AW-1:0] pc,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   instr_count
);

   import tpu_isa_pkg::*;

   fetch_state_e       state_q, state_d;
   logic [IMEM_AW-1:0] pc_q, pc_d;
   logic [INSTR_W-1:0] ibuf_q, ibuf_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               done_q, done_d;
   logic [OPC_W-1:0]   opcode;

   assign opcode = ibuf_q[INSTR_W-1 -: OPC_W];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FS_IDLE;
         pc_q    <= '0;
         ibuf_q  <= '0;
         instr_q <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ibuf_q  <= ibuf_d;
         instr_q <= instr_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // instr_d defaults to zero so an issued word is visible for exactly one cycle
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ibuf_d  = ibuf_q;
      instr_d = '0;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         FS_IDLE: begin
            if (start) begin
               pc_d    = start_pc;
               cnt_d   = '0;
               state_d = FS_FETCH;
            end
         end
         FS_FETCH: state_d = FS_RECV;
         FS_RECV: begin
            ibuf_d  = imem.imem_rdata;
            state_d = FS_ISSUE;
         end
         FS_ISSUE: begin
            if (opcode == OP_HALT) begin
               state_d = FS_DONE;
               done_d  = 1'b1;
            end else if (!stall) begin
               instr_d = ibuf_q;
               pc_d    = pc_q + IMEM_AW'(1);
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = (opcode == OP_COMPUTE) ? FS_WAIT_CMP : FS_FETCH;
            end
         end
         FS_WAIT_CMP: begin
            if (compute_done) state_d = FS_FETCH;
         end
         FS_DONE: state_d = FS_IDLE;
         default: state_d = FS_IDLE;
      endcase
   end

   assign imem.imem_en   = (state_q == FS_FETCH);
   assign imem.imem_addr = pc_q;
   assign busy           = (state_q != FS_IDLE);
   assign instruction    = instr_q;
   assign pc             = pc_q;
   assign done           = done_q;
   assign instr_count    = cnt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: per-cycle vector table for a straight-line
// program, then hand sequences for compute wait, stall, pc wrap, reset and start.
module tb_instruction_fetch;

   localparam int AW = 8;
   localparam int IW = 16;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset, start, stall, compute_done;
   logic [AW-1:0] start_pc;
   logic [IW-1:0] instruction;
   logic [AW-1:0] pc;
   logic          busy, done;
   logic [CW-1:0] instr_count;

   logic [IW-1:0] mem [256];

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [15:0] instr;
      logic        en;
      logic [7:0]  addr;
      logic        busy;
      logic        done;
   } row_t;

   row_t rows [14];

   always #5 clk = ~clk;

   instruction_fetch_if #(.IMEM_AW(AW), .INSTR_W(IW)) bus ();

   instruction_fetch #(.IMEM_AW(AW), .INSTR_W(IW), .CNT_W(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .start_pc     (start_pc),
      .stall        (stall),
      .compute_done (compute_done),
      .imem         (bus),
      .instruction  (instruction),
      .pc           (pc),
      .busy         (busy),
      .done         (done),
      .instr_count  (instr_count)
   );

   // synchronous memory model: read word valid the cycle after the enable
   always @(posedge clk) begin
      if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = '0;
   endtask

   task automatic do_start(input logic [AW-1:0] addr);
      start_pc = addr;
      start    = 1'b1;
      step();
      start    = 1'b0;
   endtask

   // steps until a non-zero word is issued; n = steps taken, -1 on timeout
   task automatic wait_issue(input int bound, output int n, output logic [IW-1:0] w);
      n = -1;
      w = '0;
      for (int k = 1; k <= bound; k++) begin
         step();
         if (instruction != '0) begin
            n = k;
            w = instruction;
            break;
         end
      end
   endtask

   task automatic wait_done(input int bound, output int n);
      n = -1;
      for (int k = 1; k <= bound; k++) begin
         step();
         if (done) begin
            n = k;
            break;
         end
      end
   endtask

   initial begin
      int            n;
      logic [IW-1:0] w;
      logic          ok;
      row_t          act;

      reset        = 1'b1;
      start        = 1'b0;
      stall        = 1'b0;
      compute_done = 1'b0;
      start_pc     = '0;
      clear_mem();
      repeat (3) step();
      reset = 1'b0;
      check("reset_state", {instruction, bus.imem_en, bus.imem_addr, busy, done, pc},
            {16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00});
      check("reset_count", 32'(instr_count), 32'd0);

      // Straight-line program: one row per cycle after the start edge
      rows[0]  = '{16'h0000, 1'b1, 8'd0, 1'b1, 1'b0};
      rows[1]  = '{16'h0000, 1'b0, 8'd0, 1'b1, 1'b0};
      rows[2]  = '{16'h0000, 1'b0, 8'd0, 1'b1, 1'b0};
      rows[3]  = '{16'h2005, 1'b1, 8'd1, 1'b1, 1'b0};
      rows[4]  = '{16'h0000, 1'b0, 8'd1, 1'b1, 1'b0};
      rows[5]  = '{16'h0000, 1'b0, 8'd1, 1'b1, 1'b0};
      rows[6]  = '{16'h4000, 1'b1, 8'd2, 1'b1, 1'b0};
      rows[7]  = '{16'h0000, 1'b0, 8'd2, 1'b1, 1'b0};
      rows[8]  = '{16'h0000, 1'b0, 8'd2, 1'b1, 1'b0};
      rows[9]  = '{16'h6000, 1'b1, 8'd3, 1'b1, 1'b0};
      rows[10] = '{16'h0000, 1'b0, 8'd3, 1'b1, 1'b0};
      rows[11] = '{16'h0000, 1'b0, 8'd3, 1'b1, 1'b0};
      rows[12] = '{16'h0000, 1'b0, 8'd3, 1'b1, 1'b1};
      rows[13] = '{16'h0000, 1'b0, 8'd3, 1'b0, 1'b0};
      mem[0] = 16'h2005; mem[1] = 16'h4000; mem[2] = 16'h6000; mem[3] = 16'hE000;
      do_start(8'h00);
      for (int i = 0; i < 14; i++) begin
         if (i > 0) step();
         act = '{instruction, bus.imem_en, bus.imem_addr, busy, done};
         check($sformatf("t1_row%0d", i), 32'(act), 32'(rows[i]));
      end
      check("t1_count", 32'(instr_count), 32'd3);
      check("t1_pc", 32'(pc), 32'd3);

      // Compute wait: no fetch until compute_done, then 3 cycles to the next issue
      clear_mem();
      mem[0] = 16'h8000; mem[1] = 16'h4000; mem[2] = 16'hE000;
      do_start(8'h00);
      wait_issue(20, n, w);
      check("t2_cmp_word", 32'(w), 32'h8000);
      check("t2_cmp_latency", 32'(n), 32'd3);
      ok = 1'b1;
      for (int k = 0; k < 9; k++) begin
         step();
         if (bus.imem_en || instruction != '0 || !busy) ok = 1'b0;
      end
      check("t2_wait_quiet", 32'(ok), 32'd1);
      compute_done = 1'b1;
      step();
      compute_done = 1'b0;
      wait_issue(20, n, w);
      check("t2_next_word", 32'(w), 32'h4000);
      check("t2_resume_latency", 32'(n), 32'd3);
      wait_done(20, n);
      check("t2_done_latency", 32'(n), 32'd3);
      check("t2_count", 32'(instr_count), 32'd2);

      // Stall held 5 cycles in ISSUE; compute_done asserted too and must not matter
      step();
      clear_mem();
      mem[0] = 16'h6000; mem[1] = 16'hE000;
      do_start(8'h00);
      step();
      stall        = 1'b1;
      compute_done = 1'b1;
      ok = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         if (instruction != '0 || bus.imem_en || !busy) ok = 1'b0;
      end
      check("t3_stall_hold", 32'(ok), 32'd1);
      check("t3_stall_count", 32'(instr_count), 32'd0);
      stall        = 1'b0;
      compute_done = 1'b0;
      step();
      check("t3_issue_word", 32'(instruction), 32'h6000);
      check("t3_issue_count", 32'(instr_count), 32'd1);
      step();
      check("t3_word_cleared", 32'(instruction), 32'h0000);
      wait_done(20, n);
      check("t3_done_latency", 32'(n), 32'd2);
      check("t3_final_count", 32'(instr_count), 32'd1);

      // pc wraps from FF to 0
      step();
      clear_mem();
      mem[8'hFF] = 16'h4000; mem[0] = 16'hE000;
      do_start(8'hFF);
      check("t4_first_fetch", {bus.imem_en, bus.imem_addr}, {1'b1, 8'hFF});
      wait_issue(20, n, w);
      check("t4_word", 32'(w), 32'h4000);
      check("t4_wrap_fetch", {bus.imem_en, bus.imem_addr}, {1'b1, 8'h00});
      wait_done(20, n);
      check("t4_done_latency", 32'(n), 32'd3);
      check("t4_pc", 32'(pc), 32'd0);

      // Reset while waiting for compute completion
      step();
      clear_mem();
      mem[0] = 16'h8000;
      do_start(8'h00);
      wait_issue(20, n, w);
      check("t5_cmp_word", 32'(w), 32'h8000);
      repeat (2) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t5_after_reset", {busy, instruction, pc, instr_count},
            {1'b0, 16'h0000, 8'h00, 16'h0000});
      compute_done = 1'b1;
      step();
      compute_done = 1'b0;
      step();
      check("t5_cmp_ignored", {busy, bus.imem_en, instruction}, {1'b0, 1'b0, 16'h0000});
      mem[0] = 16'h4000; mem[1] = 16'hE000;
      do_start(8'h00);
      wait_issue(20, n, w);
      check("t5_fresh_word", {w, 8'(n)}, {16'h4000, 8'd3});
      wait_done(20, n);
      check("t5_fresh_done", 32'(n), 32'd3);
      check("t5_fresh_count", 32'(instr_count), 32'd1);

      // start and start_pc changes while busy are ignored
      step();
      clear_mem();
      mem[10] = 16'h4000; mem[11] = 16'hE000;
      mem[20] = 16'h2222; mem[21] = 16'hE000;
      do_start(8'd10);
      start_pc = 8'd20;
      start    = 1'b1;
      wait_issue(20, n, w);
      check("t6_word", 32'(w), 32'h4000);
      check("t6_pc_mid", 32'(pc), 32'd11);
      start = 1'b0;
      wait_done(20, n);
      check("t6_done_latency", 32'(n), 32'd3);
      check("t6_final", {pc, instr_count}, {8'd11, 16'd1});
      step();
      check("t6_idle", {busy, done}, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
